// File: rtl/aes_decipher_block.sv
// aes_decipher_block: iterative AES-128/AES-256 inverse cipher. The round key comes from an
// external key memory addressed by 'round'; one state word per cycle goes through an external inverse S-box.
module aes_decipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  inv_sboxw,
  input  logic [31:0]  new_inv_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SBOX = 2'd2,
    MAIN = 2'd3
  } state_t;

  state_t       state_r;
  logic [3:0]   round_r;
  logic [1:0]   sword_ctr_r;
  logic [127:0] block_r;
  logic         ready_r;
  logic [6:0]   sword_msb_s;
  logic [31:0]  inv_sboxw_s;

  function automatic logic [7:0] xtime(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3),
            gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3)};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] d);
    return {inv_mixw(d[127:96]), inv_mixw(d[95:64]), inv_mixw(d[63:32]), inv_mixw(d[31:0])};
  endfunction

  // Row r of the state moves right by r columns.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] d);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = d;
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  // Route the addressed state word to the inverse S-box, zero outside substitution.
  always_comb begin
    sword_msb_s = 7'd127 - {sword_ctr_r, 5'd0};
    inv_sboxw_s = 32'd0;
    if (state_r == SBOX) begin
      inv_sboxw_s = block_r[sword_msb_s -: 32];
    end else begin
      inv_sboxw_s = 32'd0;
    end
  end

  // Round sequencing FSM with the state, round and ready registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      round_r     <= 4'd0;
      sword_ctr_r <= 2'd0;
      block_r     <= 128'd0;
      ready_r     <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (next) begin
            round_r <= keylen ? 4'd14 : 4'd10;
            ready_r <= 1'b0;
            state_r <= INIT;
          end
        end
        INIT: begin
          block_r     <= inv_shiftrows(block ^ round_key);
          round_r     <= round_r - 4'd1;
          sword_ctr_r <= 2'd0;
          state_r     <= SBOX;
        end
        SBOX: begin
          block_r[sword_msb_s -: 32] <= new_inv_sboxw;
          sword_ctr_r                <= sword_ctr_r + 2'd1;
          if (sword_ctr_r == 2'd3) begin
            state_r <= MAIN;
          end
        end
        MAIN: begin
          if (round_r != 4'd0) begin
            block_r     <= inv_shiftrows(inv_mixcolumns(block_r ^ round_key));
            round_r     <= round_r - 4'd1;
            sword_ctr_r <= 2'd0;
            state_r     <= SBOX;
          end else begin
            block_r <= block_r ^ round_key;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign round     = round_r;
  assign inv_sboxw = inv_sboxw_s;
  assign new_block = block_r;
  assign ready     = ready_r;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: bench-owned key memory and inverse S-box, FIPS-197 vectors plus
// random blocks scored against a byte-level InvCipher model through an expectation queue.
module tb_aes_decipher_block;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  inv_sboxw;
  logic [31:0]  new_inv_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_mem [16];

  typedef struct packed {
    logic [127:0] pt;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic rst_at_edge = 1'b1;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

  aes_decipher_block dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .next          (next),
    .keylen        (keylen),
    .round         (round),
    .round_key     (round_key),
    .inv_sboxw     (inv_sboxw),
    .new_inv_sboxw (new_inv_sboxw),
    .block         (block),
    .new_block     (new_block),
    .ready         (ready)
  );

  assign round_key     = rk_mem[round];
  assign new_inv_sboxw = {isbox[inv_sboxw[31:24]], isbox[inv_sboxw[23:16]],
                          isbox[inv_sboxw[15:8]],  isbox[inv_sboxw[7:0]]};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !reset_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic init_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'd0;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'd1) inv = 8'(b);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int nk = kl ? 8 : 4;
    int nr = kl ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'd0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
  endtask

  // Byte (column c, row r) lives at index 4c+r counted from the most significant byte.
  function automatic logic [127:0] isr(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127 - 8*(4*c+r) -: 8] = x[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] isb(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127 - 8*i -: 8] = isbox[x[127 - 8*i -: 8]];
    return y;
  endfunction

  function automatic logic [7:0] coef(input int k);
    case (k)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] imc(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'd0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef((j - r + 4) % 4), x[127 - 8*(4*c+j) -: 8]);
        y[127 - 8*(4*c+r) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
    logic [127:0] s = ct ^ rk_mem[nr];
    for (int r = nr - 1; r >= 1; r--) s = imc(isb(isr(s)) ^ rk_mem[r]);
    return isb(isr(s)) ^ rk_mem[0];
  endfunction

  // Called at a negedge; returns at the negedge after next was sampled.
  task automatic issue(input logic [255:0] key, input logic kl, input logic [127:0] ct,
                       input logic [127:0] want, input bit use_model, input bit push);
    exp_t e;
    load_key(key, kl);
    block  = ct;
    keylen = kl;
    next   = 1'b1;
    e.pt    = use_model ? ref_decrypt(ct, kl ? 14 : 10) : want;
    e.issue = cyc;
    e.lat   = kl ? 72 : 52;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {127'd0, ready}, 128'd1);
  endtask

  // Monitor: every completion not caused by reset is scored against the queue head.
  initial begin : monitor
    logic prev_rdy = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        prev_rdy = 1'b1;
      end else begin
        if (ready && !prev_rdy) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_ready", 128'd1, 128'd0);
          end else begin
            e = sb_q.pop_front();
            chk("plaintext", new_block, e.pt);
            chk("latency", 128'(cyc - e.issue), 128'(e.lat));
          end
        end
        prev_rdy = ready;
      end
    end
  end

  initial begin : stimulus
    int hist [16];
    int n, viol;
    logic [3:0] prev_round;
    logic [255:0] rkey;
    logic [127:0] rct;
    logic rkl;

    reset_n = 1'b0;
    next    = 1'b0;
    keylen  = 1'b0;
    block   = 128'd0;
    init_tables();
    load_key(256'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {127'd0, ready}, 128'd1);
    chk("reset_round", {124'd0, round}, 128'd0);
    chk("reset_new_block", new_block, 128'd0);
    chk("reset_inv_sboxw", {96'd0, inv_sboxw}, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // AES-128 vector with round tracing and keylen toggling while busy.
    issue(KEY128, 1'b0, CT128, PT, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) hist[i] = 0;
    n = 0;
    viol = 0;
    prev_round = 4'd10;
    while (!ready && n < 200) begin
      hist[round]++;
      if (round != prev_round && round != prev_round - 4'd1) viol++;
      prev_round = round;
      keylen = ~keylen;
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {127'd0, ready}, 128'd1);
    chk("round_order", 128'(viol), 128'd0);
    for (int r = 0; r <= 10; r++)
      chk($sformatf("round_%0d_cycles", r), 128'(hist[r]), (r == 10) ? 128'd1 : 128'd5);

    // AES-256 vector.
    @(negedge clk);
    issue(KEY256, 1'b1, CT256, PT, 1'b0, 1'b1);
    wait_ready();

    // next pulsed while busy, then a back-to-back start in the first idle cycle.
    @(negedge clk);
    issue(KEY128, 1'b0, CT128, PT, 1'b0, 1'b1);
    repeat (19) @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    wait_ready();
    issue(KEY256, 1'b1, CT256, PT, 1'b0, 1'b1);
    wait_ready();

    // Reset in the middle of an AES-256 run abandons it.
    @(negedge clk);
    issue(KEY256, 1'b1, CT256, PT, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {127'd0, ready}, 128'd1);
    chk("midrst_new_block", new_block, 128'd0);
    chk("midrst_round", {124'd0, round}, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    issue(KEY128, 1'b0, CT128, PT, 1'b0, 1'b1);
    wait_ready();

    // Random keys, key lengths and ciphertexts against the model.
    for (int i = 0; i < 8; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rct  = {$urandom, $urandom, $urandom, $urandom};
      rkl  = 1'($urandom_range(0, 1));
      issue(rkey, rkl, rct, 128'd0, 1'b1, 1'b1);
      keylen = 1'($urandom_range(0, 1));
      wait_ready();
      if (i % 2 == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
